// File: rtl/fifo_beat_serializer_pkg.sv
// Shared typedefs and helpers for FIFO-fed stages.
package fifo_beat_serializer_pkg;

  // Serializer control state: nothing held, or a word held with beats pending.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_SHIFT = 1'b1
  } fbs_state_e;

  // Index width for a beat counter spanning 'ratio' beats, never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_beat_serializer.sv
// Pops words from a show-ahead FIFO and emits them as OUT_WIDTH beats, LSB slice first.
module fifo_beat_serializer
  import fifo_beat_serializer_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_q,
  output logic                 fifo_rdreq,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [31:0]          words_done
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W = idx_width(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if ((OUT_WIDTH < 1) || (IN_WIDTH < OUT_WIDTH) || ((IN_WIDTH % OUT_WIDTH) != 0)) begin : g_bad_ratio
      $error("fifo_beat_serializer: IN_WIDTH must be a positive multiple of OUT_WIDTH");
    end
  endgenerate

  fbs_state_e           state_q, state_d;
  logic [IN_WIDTH-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [31:0]          done_q, done_d;
  logic                 hs;

  // Output decode; the pop also fires on the last-beat handshake so words run back-to-back.
  always_comb begin
    out_valid  = (state_q == S_SHIFT);
    out_last   = out_valid && (idx_q == LAST_IDX);
    out_data   = shift_q[OUT_WIDTH-1:0];
    hs         = out_valid & out_ready;
    fifo_rdreq = reset_n & ~fifo_empty & ((state_q == S_EMPTY) | (hs & out_last));
    words_done = done_q;
  end

  // Next state: a pop reloads the word; otherwise a handshake advances or retires it.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = done_q;
    if (fifo_rdreq) begin
      state_d = S_SHIFT;
      shift_d = fifo_q;
      idx_d   = '0;
    end else if (hs) begin
      if (out_last) begin
        state_d = S_EMPTY;
      end else begin
        shift_d = shift_q >> OUT_WIDTH;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
    if (hs && out_last) begin
      done_d = done_q + 32'd1;
    end
  end

  // State registers, cleared asynchronously so a held word is dropped at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      shift_q <= '0;
      idx_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_beat_serializer.sv
// Bench for fifo_beat_serializer: 32->8 and 32->32 instances against a beat-queue model.
module tb_fifo_beat_serializer;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fifo_empty, out_ready;
  logic [31:0] fifo_q;
  logic        rdreq_a, valid_a, last_a;
  logic [7:0]  data_a;
  logic [31:0] done_a;

  logic        fifo_empty_b, out_ready_b;
  logic [31:0] fifo_q_b;
  logic        rdreq_b, valid_b, last_b;
  logic [31:0] data_b;
  logic [31:0] done_b;

  fifo_beat_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rdreq(rdreq_a), .out_valid(valid_a), .out_data(data_a), .out_last(last_a),
    .out_ready(out_ready), .words_done(done_a)
  );

  fifo_beat_serializer #(.IN_WIDTH(32), .OUT_WIDTH(32)) dut_b (
    .clock(clock), .reset_n(reset_n), .fifo_empty(fifo_empty_b), .fifo_q(fifo_q_b),
    .fifo_rdreq(rdreq_b), .out_valid(valid_b), .out_data(data_b), .out_last(last_b),
    .out_ready(out_ready_b), .words_done(done_b)
  );

  always #5 clock = ~clock;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          gate_a = 1'b0;
  logic [31:0] fa[$];
  logic [31:0] fb[$];
  beat_t       ma[$];
  beat_t       mb[$];
  logic [31:0] wd_a = '0;
  logic [31:0] wd_b = '0;
  logic [7:0]  log_d[$];
  logic        log_l[$];
  int          log_c[$];
  int          pop_c[$];
  int          nb_last = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_log();
    log_d.delete(); log_l.delete(); log_c.delete(); pop_c.delete();
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit rdy_a, input bit rdy_b);
    logic  ea, eb, hs_a, hs_b;
    logic [31:0] w;
    out_ready    = rdy_a;
    fifo_empty   = (fa.size() == 0) || gate_a;
    fifo_q       = (fa.size() != 0) ? fa[0] : 32'h0;
    out_ready_b  = rdy_b;
    fifo_empty_b = (fb.size() == 0);
    fifo_q_b     = (fb.size() != 0) ? fb[0] : 32'h0;
    #1;
    if (!reset_n) begin
      ma.delete(); mb.delete(); wd_a = '0; wd_b = '0;
      chk("rst_data_a", {24'h0, data_a}, 32'h0);
      chk("rst_last_a", {31'h0, last_a}, 32'h0);
    end
    ea   = reset_n && !fifo_empty && (ma.size() == 0 || (rdy_a && ma[0].last));
    eb   = reset_n && !fifo_empty_b && (mb.size() == 0 || (rdy_b && mb[0].last));
    hs_a = reset_n && (ma.size() != 0) && rdy_a;
    hs_b = reset_n && (mb.size() != 0) && rdy_b;
    chk("rdreq_a", {31'h0, rdreq_a}, {31'h0, ea});
    chk("valid_a", {31'h0, valid_a}, {31'h0, ma.size() != 0});
    chk("done_a", done_a, wd_a);
    if (ma.size() != 0) begin
      chk("data_a", {24'h0, data_a}, ma[0].d);
      chk("last_a", {31'h0, last_a}, {31'h0, ma[0].last});
    end
    chk("rdreq_b", {31'h0, rdreq_b}, {31'h0, eb});
    chk("valid_b", {31'h0, valid_b}, {31'h0, mb.size() != 0});
    chk("done_b", done_b, wd_b);
    if (mb.size() != 0) begin
      chk("data_b", data_b, mb[0].d);
      chk("last_b", {31'h0, last_b}, {31'h0, mb[0].last});
    end
    if (valid_a && rdy_a) begin
      log_d.push_back(data_a); log_l.push_back(last_a); log_c.push_back(cyc);
    end
    if (rdreq_a) pop_c.push_back(cyc);
    if (valid_b && rdy_b && last_b) nb_last++;
    @(posedge clock);
    if (hs_a) begin
      if (ma[0].last) wd_a = wd_a + 32'd1;
      void'(ma.pop_front());
    end
    if (ea) begin
      w = fa.pop_front();
      for (int k = 0; k < 4; k++) ma.push_back('{(w >> (8 * k)) & 32'hff, k == 3});
    end
    if (hs_b) begin
      wd_b = wd_b + 32'd1;
      void'(mb.pop_front());
    end
    if (eb) mb.push_back('{fb.pop_front(), 1'b1});
    cyc++;
    @(negedge clock);
  endtask

  // Asynchronous reset asserted between edges, checked before any clock arrives.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    chk("rst_async_valid_a", {31'h0, valid_a}, 32'h0);
    chk("rst_async_rdreq_a", {31'h0, rdreq_a}, 32'h0);
    chk("rst_async_done_a", done_a, 32'h0);
    chk("rst_async_valid_b", {31'h0, valid_b}, 32'h0);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; fifo_empty = 1'b1; out_ready = 1'b0; fifo_q = '0;
    fifo_empty_b = 1'b1; out_ready_b = 1'b0; fifo_q_b = '0;
    @(negedge clock);
    do_reset(3);

    // Single word, LSB slice first; also three words through the 32-bit instance.
    clear_log();
    fa.push_back(32'hDDCCBBAA);
    fb.push_back(32'h1); fb.push_back(32'h2); fb.push_back(32'h3);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    chk("single_nbeats", log_d.size(), 4);
    if (log_d.size() == 4) begin
      chk("single_b0", {24'h0, log_d[0]}, 32'hAA);
      chk("single_b1", {24'h0, log_d[1]}, 32'hBB);
      chk("single_b2", {24'h0, log_d[2]}, 32'hCC);
      chk("single_b3", {24'h0, log_d[3]}, 32'hDD);
      chk("single_lasts", {28'h0, log_l[3], log_l[2], log_l[1], log_l[0]}, 32'h8);
      chk("single_consec", log_c[3] - log_c[0], 3);
      chk("single_latency", log_c[0] - pop_c[0], 1);
    end
    chk("single_done", done_a, 32'd1);
    chk("ratio1_done", done_b, 32'd3);
    chk("ratio1_lasts", nb_last, 3);

    // Back-to-back words with no bubble.
    clear_log();
    fa.push_back(32'h04030201); fa.push_back(32'h08070605);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    chk("b2b_nbeats", log_d.size(), 8);
    chk("b2b_npops", pop_c.size(), 2);
    if (log_d.size() == 8 && pop_c.size() == 2) begin
      for (int i = 0; i < 8; i++) chk("b2b_beat", {24'h0, log_d[i]}, i + 1);
      chk("b2b_consec", log_c[7] - log_c[0], 7);
      chk("b2b_pop_gap", pop_c[1] - pop_c[0], 4);
      chk("b2b_first_beat", log_c[0] - pop_c[0], 1);
    end

    // Backpressure on beat 2, with another word waiting in the FIFO.
    fa.push_back(32'h44332211); fa.push_back(32'h99887766);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data", {24'h0, data_a}, 32'h33);
      chk("bp_hold_valid", {31'h0, valid_a}, 32'h1);
      chk("bp_no_pop", {31'h0, rdreq_a}, 32'h0);
      step(1'b0, 1'b1);
    end
    clear_log();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
    chk("bp_resume_n", log_d.size(), 2);
    if (log_d.size() == 2) begin
      chk("bp_resume0", {24'h0, log_d[0]}, 32'h33);
      chk("bp_resume1", {24'h0, log_d[1]}, 32'h44);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

    // Empty FIFO: nothing moves.
    for (int i = 0; i < 20; i++) begin
      chk("empty_rdreq", {31'h0, rdreq_a}, 32'h0);
      chk("empty_valid", {31'h0, valid_a}, 32'h0);
      step(1'b1, 1'b1);
    end

    // Reset after beat 1 drops the word; the next word starts at its LSB slice.
    fa.push_back(32'h44332211);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    do_reset(2);
    chk("midrst_done", done_a, 32'h0);
    clear_log();
    fa.push_back(32'hA0B0C0D0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    chk("midrst_nbeats", log_d.size(), 4);
    if (log_d.size() != 0) chk("midrst_first", {24'h0, log_d[0]}, 32'hD0);
    chk("midrst_done_after", done_a, 32'd1);

    // Randomized traffic, bubbles, backpressure and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0 && fa.size() < 6) fa.push_back($urandom);
      if ($urandom_range(0, 3) == 0 && fb.size() < 6) fb.push_back($urandom);
      gate_a = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
    gate_a = 1'b0;
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
    chk("drain_a", fa.size() + ma.size(), 0);
    chk("drain_b", fb.size() + mb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
